// File: rtl/afifo_wr_arbiter_pkg.sv
// Shared types and helpers for the async-FIFO write-port arbiter.
//   afifo_arb_state_e : arbiter FSM state (IDLE = arbitrate, BURST = owner writes)
//   id_width()        : width of a requester index, never below 1 bit
package afifo_wr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } afifo_arb_state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/afifo_wr_arbiter_if.sv
// Requester / FIFO write-side bundle of the write arbiter.
//   req_valid/req_data/req_ready : per-requester beat handshake
//   wfull                        : FIFO full flag (wclk domain)
//   winc/wdata                   : FIFO write port
//   grant_active/grant_id        : current (or last) burst owner
// The arbiter uses the slave view; producers/FIFO/bench use the master view.
interface afifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    import afifo_wr_arbiter_pkg::*;

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wfull;
    logic                          winc;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          grant_active;
    logic [ID_W-1:0]               grant_id;

    modport slave (
        input  req_valid, req_data, wfull,
        output req_ready, winc, wdata, grant_active, grant_id
    );

    modport master (
        output req_valid, req_data, wfull,
        input  req_ready, winc, wdata, grant_active, grant_id
    );

endinterface

// File: rtl/afifo_wr_arbiter_rr_picker.sv
// Rotating-priority encoder.
//   req_i   : request vector
//   ptr_i   : last winner; search order is ptr_i+1, ptr_i+2, ... modulo NUM_REQ
//   found_o : any request present
//   idx_o   : index of the first request in search order
module afifo_rr_picker
    import afifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               found_o,
    output logic [ID_W-1:0]    idx_o
);

    int                 cand;
    logic [NUM_REQ-1:0] req_sh;

    // Walk from the lowest priority (offset NUM_REQ, i.e. ptr itself) up to
    // the highest (offset 1) so the last hit is the winner.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        req_sh  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand   = (int'(ptr_i) + i) % NUM_REQ;
            req_sh = req_i >> cand;
            if (req_sh[0]) begin
                found_o = 1'b1;
                idx_o   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter sharing the async-FIFO write port among NUM_REQ
// requesters. Each grant is a burst of at most MAX_BURST beats; one idle
// cycle is spent arbitrating between bursts.
//   wclk   : write-domain clock
//   wrst_n : asynchronous active-low reset
//   bus    : slave view of afifo_wr_arbiter_if (requesters, wfull, winc/wdata, grant status)
module afifo_wr_arbiter
    import afifo_wr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic               wclk,
    input  logic               wrst_n,
    afifo_wr_arbiter_if.slave  bus
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    afifo_arb_state_e          state_q, state_d;
    logic [ID_W-1:0]           owner_q, owner_d;
    logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;

    logic                      pick_found;
    logic [ID_W-1:0]           pick_idx;
    logic                      in_burst;
    logic                      own_valid;
    logic [NUM_REQ-1:0]        vld_sh;
    logic [NUM_REQ*DATA_WIDTH-1:0] dat_sh;
    logic                      winc_w;

    afifo_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Output mux: everything is decoded from registered state/owner, so the
    // async reset forces the outputs low without waiting for a clock edge.
    always_comb begin
        in_burst  = (state_q == ARB_BURST);
        vld_sh    = bus.req_valid >> owner_q;
        own_valid = vld_sh[0];
        dat_sh    = bus.req_data >> (int'(owner_q) * DATA_WIDTH);
        winc_w    = in_burst && own_valid && !bus.wfull;

        bus.winc         = winc_w;
        bus.wdata        = in_burst ? dat_sh[DATA_WIDTH-1:0] : '0;
        bus.req_ready    = (in_burst && !bus.wfull) ? (NUM_REQ'(1) << owner_q) : '0;
        bus.grant_active = in_burst;
        bus.grant_id     = owner_q;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ARB_BURST;
                end
            end
            default: begin
                // Only real writes consume burst budget; wfull stalls do not.
                if (winc_w) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // Owner leaving (even while stalled) or budget exhausted
                // both hand the port back and move the priority pointer.
                if (!own_valid ||
                    (winc_w && (beat_cnt_q == CNT_W'(MAX_BURST - 1)))) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = owner_q;
                end
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
module tb_afifo_wr_arbiter;
    import afifo_wr_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 4;

    typedef struct {
        logic [31:0] data;
        int          id;
        int          off;
    } exp_t;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;

    always #5 wclk = ~wclk;

    afifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    afifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          t0      = 0;
    int          full_lo = 1000;
    int          full_hi = -1;
    exp_t        exp_q[$];
    logic [31:0] src_data [NR][16];
    int          src_len  [NR];
    int          src_pos  [NR];

    always @(posedge wclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input int id, input int off);
        exp_t e;
        e.data = d;
        e.id   = id;
        e.off  = off;
        exp_q.push_back(e);
    endtask

    task automatic load(input int i, input int n, input logic [31:0] base);
        for (int j = 0; j < n; j++) src_data[i][j] = base + 32'(j);
        src_pos[i] = 0;
        src_len[i] = n;
    endtask

    task automatic drain(input int budget, input int last_id);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge wclk);
            n++;
        end
        check("drain_pending_beats", exp_q.size(), 0);
        repeat (4) @(negedge wclk);
        check("idle_grant_active", bus.grant_active, 0);
        check("idle_grant_id_held", bus.grant_id, last_id);
    endtask

    // Requester model: pops a word after each accepted beat, holds data stable otherwise.
    initial begin
        logic [NR-1:0] acc;
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.wfull     = 1'b0;
        forever begin
            @(negedge wclk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge wclk);
            #1;
            for (int i = 0; i < NR; i++) if (acc[i]) src_pos[i]++;
            for (int i = 0; i < NR; i++) begin
                bus.req_valid[i]         = (src_pos[i] < src_len[i]);
                bus.req_data[i*DW +: DW] = (src_pos[i] < src_len[i] && src_pos[i] < 16) ?
                                           src_data[i][src_pos[i]] : '0;
            end
            bus.wfull = ((cyc - t0) >= full_lo) && ((cyc - t0) <= full_hi);
        end
    end

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            if (wrst_n) begin
                if (bus.wfull) begin
                    check("winc_while_full", bus.winc, 0);
                    check("ready_while_full", bus.req_ready, 0);
                end
                if (bus.winc) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_winc: got wdata %0h id %0d, expected no write (cycle %0d)",
                                 bus.wdata, bus.grant_id, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("wdata", bus.wdata, e.data);
                        check("grant_id", bus.grant_id, e.id);
                        check("beat_cycle", cyc - t0, e.off);
                        check("req_ready", bus.req_ready, 64'(1) << e.id);
                        check("grant_active", bus.grant_active, 1);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge wclk);
        check("rst_winc", bus.winc, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_grant_active", bus.grant_active, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_wdata", bus.wdata, 0);
        wrst_n = 1'b1;
        repeat (2) @(negedge wclk);

        // All four valid: bursts 0,1,2,3,0 of 4 beats, 1 idle cycle between
        load(0, 8, 32'h1000_0000);
        load(1, 4, 32'h2000_0000);
        load(2, 4, 32'h3000_0000);
        load(3, 4, 32'h4000_0000);
        t0 = cyc + 1;
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 4; k++)
                expect_beat(32'((b % 4) + 1) * 32'h1000_0000 + 32'((b / 4) * 4 + k), b % 4, b * 5 + k + 1);
        drain(60, 0);

        // Owner 1 leaves after 2 beats; 3 wins next (search from 2), then 0
        load(1, 2, 32'h5100);
        load(0, 2, 32'h5000);
        load(3, 2, 32'h5300);
        t0 = cyc + 1;
        expect_beat(32'h5100, 1, 1);
        expect_beat(32'h5101, 1, 2);
        expect_beat(32'h5300, 3, 5);
        expect_beat(32'h5301, 3, 6);
        expect_beat(32'h5000, 0, 9);
        expect_beat(32'h5001, 0, 10);
        drain(30, 0);

        // Single requester 2: 4 beats, 1-cycle gap, re-granted for 2 more
        load(2, 6, 32'hA0);
        t0 = cyc + 1;
        expect_beat(32'hA0, 2, 1);
        expect_beat(32'hA1, 2, 2);
        expect_beat(32'hA2, 2, 3);
        expect_beat(32'hA3, 2, 4);
        expect_beat(32'hA4, 2, 6);
        expect_beat(32'hA5, 2, 7);
        drain(30, 2);

        // wfull for 3 cycles after the 2nd beat; stall does not use budget
        load(3, 4, 32'hC0);
        t0      = cyc + 1;
        full_lo = 3;
        full_hi = 5;
        expect_beat(32'hC0, 3, 1);
        expect_beat(32'hC1, 3, 2);
        expect_beat(32'hC2, 3, 6);
        expect_beat(32'hC3, 3, 7);
        drain(30, 3);
        full_lo = 1000;
        full_hi = -1;

        // Reset pulsed mid-burst of requester 2
        load(2, 6, 32'hE0);
        t0 = cyc + 1;
        expect_beat(32'hE0, 2, 1);
        expect_beat(32'hE1, 2, 2);
        repeat (4) @(posedge wclk);
        #2;
        check("pre_rst_winc", bus.winc, 1);
        wrst_n = 1'b0;
        #1;
        check("async_rst_winc", bus.winc, 0);
        check("async_rst_req_ready", bus.req_ready, 0);
        check("async_rst_grant_active", bus.grant_active, 0);
        check("async_rst_grant_id", bus.grant_id, 0);
        check("async_rst_wdata", bus.wdata, 0);
        check("rst_pending_beats", exp_q.size(), 0);
        @(negedge wclk);
        load(0, 2, 32'hF0);
        @(posedge wclk);
        #3;
        wrst_n = 1'b1;
        t0     = cyc;
        expect_beat(32'hF0, 0, 1);
        expect_beat(32'hF1, 0, 2);
        expect_beat(32'hE2, 2, 5);
        expect_beat(32'hE3, 2, 6);
        expect_beat(32'hE4, 2, 7);
        expect_beat(32'hE5, 2, 8);
        drain(30, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
